// File: rtl/classify_pkg.sv
// Shared types and defaults for the classifier argmax scheduler.
// Optional build macro used by this slice: CLASSIFY_SIGNED_EN (two's-complement scores, rectified).
package classify_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int idx_w_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int NUM_CLASSES_DEF = 10;
  localparam int DATA_W_DEF      = 8;
  localparam int IDX_W_DEF       = idx_w_for(NUM_CLASSES_DEF);

endpackage

// File: rtl/classify_cmp_stage.sv
// Combinational rectify + compare unit: flags when a candidate should replace the running max.
// With CLASSIFY_SIGNED_EN defined, negative candidates are clamped to zero first.
module classify_cmp_stage
  import classify_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] cand,
  input  logic [DATA_W-1:0] cur_max,
  input  logic              first,
  output logic              take,
  output logic [DATA_W-1:0] cand_rect
);

`ifdef CLASSIFY_SIGNED_EN
  assign cand_rect = cand[DATA_W-1] ? '0 : cand;
`else
  assign cand_rect = cand;
`endif

  // strict compare: ties keep the earlier (lower) index
  assign take = first || (cand_rect > cur_max);

endmodule

// File: rtl/classify_sched.sv
// Sequential argmax over NUM_CLASSES streamed scores using a single comparator.
// Honours CLASSIFY_SIGNED_EN through classify_cmp_stage.
//
// state | meaning
// IDLE  | waiting for start, no scores consumed
// ACCUM | accepting scores, tracking running max and its index
// DONE  | result presented until result_ready
module classify_sched
  import classify_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IDX_W       = idx_w_for(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              score_valid,
  output logic              score_ready,
  input  logic [DATA_W-1:0] score_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_score,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  count;
  logic              accept;
  logic              take;
  logic [DATA_W-1:0] cand_rect;

  assign accept = score_valid && (state == ACCUM);

  classify_cmp_stage #(.DATA_W(DATA_W)) u_cmp (
    .cand      (score_data),
    .cur_max   (max_score),
    .first     (count == '0),
    .take      (take),
    .cand_rect (cand_rect)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && (count == LAST_IDX)) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake flags are flopped from the next state so they track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      score_ready  <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      score_ready  <= (state_nxt == ACCUM);
      result_valid <= (state_nxt == DONE);
      busy         <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      class_idx <= '0;
      max_score <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end
      if (accept && take) begin
        max_score <= cand_rect;
        class_idx <= count;
      end
    end
  end

endmodule

// File: tb/tb_classify_sched.sv
// Directed self-checking bench for classify_sched; honours CLASSIFY_SIGNED_EN when defined.
module tb_classify_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       score_valid;
  logic       score_ready;
  logic [7:0] score_data;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] class_idx;
  logic [7:0] max_score;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CLASSIFY_SIGNED_EN
  localparam logic [7:0] BIG = 8'd100;
`else
  localparam logic [7:0] BIG = 8'd200;
`endif

  classify_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .score_valid  (score_valid),
    .score_ready  (score_ready),
    .score_data   (score_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_idx    (class_idx),
    .max_score    (max_score),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge in IDLE; returns at the negedge where result_valid is seen (or timeout).
  task automatic run_vec(input logic [7:0] v [10], input int g [10], output int lat, output bit early);
    lat   = 0;
    early = 0;
    start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < g[i]; k++) begin
        score_valid = 1'b0;
        score_data  = 8'hAA;
        @(negedge clk); lat++;
        if (result_valid) early = 1;
      end
      score_valid = 1'b1;
      score_data  = v[i];
      @(negedge clk); lat++;
      if (i < 9 && result_valid) early = 1;
    end
    score_valid = 1'b0;
    for (int k = 0; k < 40 && !result_valid; k++) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v [10];
    int g [10];
    int lat;
    bit early;
    @(negedge clk);
    n_cmp++; if (score_ready !== 1'b0)  begin n_err++; $display("FAIL rst_score_ready got %b want 0", score_ready); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL rst_result_valid got %b want 0", result_valid); end
    n_cmp++; if (class_idx !== 4'd0)    begin n_err++; $display("FAIL rst_class_idx got %0d want 0", class_idx); end
    n_cmp++; if (max_score !== 8'd0)    begin n_err++; $display("FAIL rst_max_score got %0d want 0", max_score); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    score_valid = 1'b1;
    score_data  = 8'd250;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (score_ready !== 1'b0) begin n_err++; $display("FAIL idle_score_ready got %b want 0", score_ready); end
      n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    end
    score_valid = 1'b0;
    // if IDLE scores had been consumed, this vector would be misaligned
    v = '{8'd3, 8'd7, 8'd2, 8'd9, 8'd1, 8'd0, 8'd4, 8'd9, 8'd8, 8'd5};
    g = '{default: 0};
    run_vec(v, g, lat, early);
    n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", result_valid); end
    n_cmp++; if (lat !== 11)            begin n_err++; $display("FAIL basic_latency got %0d want 11", lat); end
    n_cmp++; if (early !== 1'b0)        begin n_err++; $display("FAIL basic_early_valid got %b want 0", early); end
    n_cmp++; if (class_idx !== 4'd3)    begin n_err++; $display("FAIL basic_class_idx got %0d want 3", class_idx); end
    n_cmp++; if (max_score !== 8'd9)    begin n_err++; $display("FAIL basic_max_score got %0d want 9", max_score); end
    handshake();
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %b want 0", result_valid); end
  endtask

  task automatic test_equal();
    logic [7:0] v [10];
    int g [10];
    int lat;
    bit early;
    v = '{default: 8'd42};
    g = '{default: 0};
    run_vec(v, g, lat, early);
    n_cmp++; if (class_idx !== 4'd0)  begin n_err++; $display("FAIL equal_class_idx got %0d want 0", class_idx); end
    n_cmp++; if (max_score !== 8'd42) begin n_err++; $display("FAIL equal_max_score got %0d want 42", max_score); end
    handshake();
  endtask

  task automatic test_gaps();
    logic [7:0] v [10];
    int g [10];
    int lat;
    bit early;
    v = '{8'd10, 8'd20, 8'd30, 8'd5, 8'd50, 8'd60, BIG, 8'd70, 8'd80, 8'd90};
    g = '{2, 1, 3, 0, 2, 1, 2, 1, 2, 1};
    run_vec(v, g, lat, early);
    n_cmp++; if (lat !== 26)         begin n_err++; $display("FAIL gaps_latency got %0d want 26", lat); end
    n_cmp++; if (class_idx !== 4'd6) begin n_err++; $display("FAIL gaps_class_idx got %0d want 6", class_idx); end
    n_cmp++; if (max_score !== BIG)  begin n_err++; $display("FAIL gaps_max_score got %0d want %0d", max_score, BIG); end
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      score_valid = 1'b1;
      score_data  = 8'd255;
      @(negedge clk);
      n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid cyc %0d got %b want 1", c, result_valid); end
      n_cmp++; if (class_idx !== 4'd6)    begin n_err++; $display("FAIL hold_class_idx cyc %0d got %0d want 6", c, class_idx); end
      n_cmp++; if (max_score !== BIG)     begin n_err++; $display("FAIL hold_max_score cyc %0d got %0d want %0d", c, max_score, BIG); end
    end
    score_valid = 1'b0;
    start = 1'b1;
    handshake();
    start = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL hs_valid got %b want 0", result_valid); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL hs_start_ignored busy got %b want 0", busy); end
    // ascending 0..9 launched right after the handshake
    for (int i = 0; i < 10; i++) v[i] = 8'(i);
    g = '{default: 0};
    run_vec(v, g, lat, early);
    n_cmp++; if (lat !== 11)         begin n_err++; $display("FAIL asc_latency got %0d want 11", lat); end
    n_cmp++; if (class_idx !== 4'd9) begin n_err++; $display("FAIL asc_class_idx got %0d want 9", class_idx); end
    n_cmp++; if (max_score !== 8'd9) begin n_err++; $display("FAIL asc_max_score got %0d want 9", max_score); end
    handshake();
  endtask

  task automatic test_start_after_hs();
    logic [7:0] v [10];
    int g [10];
    int lat;
    bit early;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1)        begin n_err++; $display("FAIL start_busy got %b want 1", busy); end
    n_cmp++; if (score_ready !== 1'b1) begin n_err++; $display("FAIL start_score_ready got %b want 1", score_ready); end
    // partial vector aborted by reset after 5 accepts
    v = '{8'd1, 8'd120, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 5; i++) begin
      score_valid = 1'b1;
      score_data  = v[i];
      @(negedge clk);
    end
    score_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (score_ready !== 1'b0)  begin n_err++; $display("FAIL abort_score_ready got %b want 0", score_ready); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL abort_result_valid got %b want 0", result_valid); end
    n_cmp++; if (class_idx !== 4'd0)    begin n_err++; $display("FAIL abort_class_idx got %0d want 0", class_idx); end
    n_cmp++; if (max_score !== 8'd0)    begin n_err++; $display("FAIL abort_max_score got %0d want 0", max_score); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd50, 8'd2, 8'd50, 8'd6, 8'd7, 8'd8};
    g = '{default: 0};
    run_vec(v, g, lat, early);
    n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL post_abort_valid got %b want 1", result_valid); end
    n_cmp++; if (lat !== 11)            begin n_err++; $display("FAIL post_abort_latency got %0d want 11", lat); end
    n_cmp++; if (class_idx !== 4'd4)    begin n_err++; $display("FAIL post_abort_class_idx got %0d want 4", class_idx); end
    n_cmp++; if (max_score !== 8'd50)   begin n_err++; $display("FAIL post_abort_max_score got %0d want 50", max_score); end
    handshake();
  endtask

  task automatic test_signed();
    logic [7:0] v [10];
    int g [10];
    int lat;
    bit early;
    v = '{8'hF0, 8'h80, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    g = '{default: 0};
    run_vec(v, g, lat, early);
`ifdef CLASSIFY_SIGNED_EN
    n_cmp++; if (class_idx !== 4'd2)  begin n_err++; $display("FAIL signed_class_idx got %0d want 2", class_idx); end
    n_cmp++; if (max_score !== 8'h05) begin n_err++; $display("FAIL signed_max_score got %0d want 5", max_score); end
`else
    n_cmp++; if (class_idx !== 4'd3)  begin n_err++; $display("FAIL raw_class_idx got %0d want 3", class_idx); end
    n_cmp++; if (max_score !== 8'hFF) begin n_err++; $display("FAIL raw_max_score got %0d want 255", max_score); end
`endif
    handshake();
    v = '{8'h80, 8'hFF, 8'hC0, 8'hFE, 8'h81, 8'hF0, 8'hA0, 8'h90, 8'hFF, 8'hFD};
    run_vec(v, g, lat, early);
`ifdef CLASSIFY_SIGNED_EN
    n_cmp++; if (class_idx !== 4'd0) begin n_err++; $display("FAIL neg_class_idx got %0d want 0", class_idx); end
    n_cmp++; if (max_score !== 8'd0) begin n_err++; $display("FAIL neg_max_score got %0d want 0", max_score); end
`else
    n_cmp++; if (class_idx !== 4'd1)  begin n_err++; $display("FAIL rawneg_class_idx got %0d want 1", class_idx); end
    n_cmp++; if (max_score !== 8'hFF) begin n_err++; $display("FAIL rawneg_max_score got %0d want 255", max_score); end
`endif
    handshake();
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    score_valid  = 1'b0;
    score_data   = 8'd0;
    result_ready = 1'b0;
    test_reset();
    test_equal();
    test_gaps();
    test_start_after_hs();
    test_signed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
